// File: rtl/lava_pkg.sv
// Shared fixed-point types and FSM states for the metaball field shader.
// Field values are signed Q16.15 held in 32 bits.
package lava_pkg;

    typedef logic signed [31:0] fp_t;
    typedef logic [11:0]        rgb_t;

    localparam int  FP_FRAC = 15;
    localparam fp_t FP_ONE  = fp_t'(1) << FP_FRAC;
    localparam fp_t FP_MAX  = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SUM,
        CLASS,
        EMIT
    } shd_state_t;

    // A ball can report a negative contribution; it must never pull the total down.
    function automatic fp_t fp_clamp_neg(input fp_t v);
        return v[31] ? fp_t'(0) : v;
    endfunction

endpackage

// File: rtl/fp_sat_add.sv
// Saturating adder for non-negative Q16.15 values; the result pins at FP_MAX
// instead of wrapping into the sign bit.
module fp_sat_add
    import lava_pkg::*;
(
    input  fp_t a,
    input  fp_t b,
    output fp_t y
);

    logic [32:0] wide;

    always_comb begin
        wide = {1'b0, a} + {1'b0, b};
        y    = (wide > {1'b0, FP_MAX}) ? FP_MAX : fp_t'(wide[31:0]);
    end

endmodule

// File: rtl/field_shader.sv
// Collects per-ball field contributions, sums them with saturation and maps the
// total onto an iso-surface colour handed out over valid/ready.
module field_shader
    import lava_pkg::*;
#(
    parameter int   N_BALLS  = 4,
    parameter fp_t  THRESH   = FP_ONE,
    parameter fp_t  CORE_LVL = 32'sh0001_0000,
    parameter int   TIMEOUT  = 1023,
    parameter rgb_t BG_RGB   = 12'h012,
    parameter rgb_t EDGE_RGB = 12'hF40,
    parameter rgb_t CORE_RGB = 12'hFC0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   px_stb,
    input  logic [N_BALLS-1:0]     ball_vld,
    input  logic [32*N_BALLS-1:0]  ball_out,
    output rgb_t                   rgb,
    output logic                   rgb_vld,
    input  logic                   rgb_rdy,
    output logic                   busy,
    output logic                   ovr,
    output logic                   tmo
);

    localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    shd_state_t          state, state_nx;
    logic [N_BALLS-1:0]  vld_q, flag, rise;
    fp_t                 cap [N_BALLS];
    fp_t                 sum, sum_nx, addend;
    logic [IW-1:0]       idx;
    logic [TW-1:0]       timer;
    logic                all_cap, tmo_hit, last_idx;

    // Only fresh rising edges count, so a level left high from the last pixel is ignored.
    assign rise     = ball_vld & ~vld_q;
    assign all_cap  = &flag;
    assign tmo_hit  = (timer == TW'(TIMEOUT));
    assign last_idx = (idx == IW'(N_BALLS - 1));
    assign addend   = fp_clamp_neg(cap[idx]);

    fp_sat_add u_add (
        .a (sum),
        .b (addend),
        .y (sum_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        rgb_vld  = (state == EMIT);
        unique case (state)
            IDLE:    if (px_stb) state_nx = WAIT;
            WAIT: begin
                if (all_cap)      state_nx = SUM;
                else if (tmo_hit) state_nx = EMIT;
            end
            SUM:     if (last_idx) state_nx = CLASS;
            CLASS:   state_nx = EMIT;
            EMIT:    if (rgb_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            flag  <= '0;
            sum   <= '0;
            idx   <= '0;
            timer <= '0;
            rgb   <= BG_RGB;
            ovr   <= 1'b0;
            tmo   <= 1'b0;
            for (int i = 0; i < N_BALLS; i++) cap[i] <= '0;
        end else begin
            vld_q <= ball_vld;
            if (px_stb && state != IDLE) ovr <= 1'b1;
            case (state)
                IDLE: begin
                    if (px_stb) begin
                        flag  <= '0;
                        timer <= '0;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    for (int i = 0; i < N_BALLS; i++) begin
                        if (rise[i] && !flag[i]) begin
                            cap[i]  <= fp_t'(ball_out[32*i +: 32]);
                            flag[i] <= 1'b1;
                        end
                    end
                    if (!all_cap && tmo_hit) begin
                        tmo <= 1'b1;
                        rgb <= BG_RGB;
                    end
                end
                SUM: begin
                    sum <= sum_nx;
                    idx <= idx + IW'(1);
                end
                CLASS: begin
                    if (sum >= CORE_LVL)    rgb <= CORE_RGB;
                    else if (sum >= THRESH) rgb <= EDGE_RGB;
                    else                    rgb <= BG_RGB;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_field_shader.sv
// Bench for field_shader: reset, table vectors, random pixels against a sum/threshold
// model, plus hand sequences for N=2 latency, overrun, timeout, stale vld and reset.
module tb_field_shader;
    import lava_pkg::*;

    localparam rgb_t BG   = 12'h012;
    localparam rgb_t EDGE = 12'hF40;
    localparam rgb_t CORE = 12'hFC0;
    localparam int   TMO  = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, px_stb, rgb_rdy, rgb_vld, busy, ovr, tmo;
    logic [3:0]   ball_vld;
    logic [127:0] ball_out;
    rgb_t         rgb;

    logic         n2_stb, n2_rdy, n2_rgb_vld, n2_busy, n2_ovr, n2_tmo;
    logic [1:0]   n2_vld;
    logic [63:0]  n2_out;
    rgb_t         n2_rgb;

    field_shader #(.N_BALLS(4)) u_dut (
        .clk(clk), .rst(rst), .px_stb(px_stb), .ball_vld(ball_vld), .ball_out(ball_out),
        .rgb(rgb), .rgb_vld(rgb_vld), .rgb_rdy(rgb_rdy), .busy(busy), .ovr(ovr), .tmo(tmo)
    );

    field_shader #(.N_BALLS(2)) u_dut2 (
        .clk(clk), .rst(rst), .px_stb(n2_stb), .ball_vld(n2_vld), .ball_out(n2_out),
        .rgb(n2_rgb), .rgb_vld(n2_rgb_vld), .rgb_rdy(n2_rdy), .busy(n2_busy), .ovr(n2_ovr),
        .tmo(n2_tmo)
    );

    typedef struct {
        logic [3:0][31:0] v;
        logic [3:0][7:0]  d;
        int               hold;
        rgb_t             exp;
    } vec_t;

    vec_t tbl [9];
    vec_t rv;
    int   n_vec = 0, n_bad = 0, cyc = 0;
    int   s, seen, bad;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] v0, v1, v2, v3,
                                input int d0, d1, d2, d3, input int hold, input rgb_t exp);
        vec_t r;
        r.v    = {v3, v2, v1, v0};
        r.d    = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        r.hold = hold;
        r.exp  = exp;
        return r;
    endfunction

    // Total of the non-negative contributions, pinned at the Q16.15 maximum.
    function automatic rgb_t model(input logic [3:0][31:0] v);
        longint tot;
        tot = 0;
        for (int i = 0; i < 4; i++)
            if (!v[i][31]) tot += longint'(v[i]);
        if (tot > 64'h7FFF_FFFF) tot = 64'h7FFF_FFFF;
        if (tot >= 64'h1_0000)      return CORE;
        else if (tot >= 64'h8000)   return EDGE;
        else                        return BG;
    endfunction

    // One pixel on the 4-ball DUT; ball i edges d[i] cycles after px_stb.
    task automatic run_pixel(input string nm, input vec_t t, input int stb_at);
        int st, last, sn;
        px_stb = 1'b1;
        tick();
        px_stb   = 1'b0;
        ball_vld = '0;
        st = cyc; last = 0; sn = -1;
        for (int k = 1; k <= 200 && sn < 0; k++) begin
            if (k == stb_at) px_stb = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (int'(t.d[i]) == k) begin
                    ball_vld[i]          = 1'b1;
                    ball_out[32*i +: 32] = t.v[i];
                    last                 = st + k;
                end
            end
            tick();
            px_stb = 1'b0;
            if (rgb_vld) sn = cyc;
        end
        check({nm, " rgb_vld seen"}, 32'(sn >= 0), 32'd1);
        if (sn < 0) return;
        check({nm, " latency"}, sn - last, 32'd6);
        check({nm, " rgb"}, rgb, t.exp);
        for (int h = 0; h < t.hold; h++) begin
            tick();
            check({nm, " held"}, {rgb_vld, rgb}, {1'b1, t.exp});
        end
        rgb_rdy = 1'b1;
        tick();
        rgb_rdy = 1'b0;
        check({nm, " released"}, {rgb_vld, busy}, 2'b00);
    endtask

    initial begin
        tbl[0] = mk(32'h0000_4000, 32'h0000_4000, 0, 0,            2, 5, 3, 4,  0, EDGE);
        tbl[1] = mk(32'h7FFF_0000, 32'h0002_0000, 0, 0,            3, 3, 3, 3,  0, CORE);
        tbl[2] = mk(32'hFFFF_8000, 32'h0000_8000, 0, 0,            2, 4, 6, 8, 10, EDGE);
        tbl[3] = mk(32'hFFFF_8000, 32'h0001_0000, 0, 0,            7, 2, 2, 2,  0, CORE);
        tbl[4] = mk(32'h0000_7FFF, 0, 0, 0,                        2, 3, 2, 3,  0, BG);
        tbl[5] = mk(32'h0000_FFFF, 32'h0000_0001, 0, 0,            4, 4, 2, 5,  0, CORE);
        tbl[6] = mk(32'h0000_8000, 32'h0000_7FFF, 0, 0,            2, 2, 9, 2,  2, EDGE);
        tbl[7] = mk(32'h8000_0000, 0, 0, 32'h0000_8000,            5, 4, 3, 2,  0, EDGE);
        tbl[8] = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                    2, 2, 2, 2, 1, CORE);

        rst = 1'b1; px_stb = 1'b0; rgb_rdy = 1'b0; ball_vld = '0; ball_out = '0;
        n2_stb = 1'b0; n2_rdy = 1'b1; n2_vld = '0; n2_out = '0;
        repeat (3) tick();
        check("reset rgb", rgb, BG);
        check("reset flags", {rgb_vld, busy, ovr, tmo}, 4'b0000);
        check("reset n2 busy", {n2_rgb_vld, n2_busy}, 2'b00);
        rst = 1'b0;
        tick();

        // Two balls, edges at +5 and +9: pixel valid 4 cycles after the second.
        n2_stb = 1'b1;
        tick();
        n2_stb = 1'b0; n2_vld = '0; s = cyc; seen = -1;
        for (int k = 1; k <= 40 && seen < 0; k++) begin
            if (k == 5) begin n2_vld[0] = 1'b1; n2_out[31:0]  = 32'h4000; end
            if (k == 9) begin n2_vld[1] = 1'b1; n2_out[63:32] = 32'h4000; end
            tick();
            if (n2_rgb_vld) seen = cyc;
        end
        check("n2 latency", seen - s, 32'd13);
        check("n2 rgb", n2_rgb, EDGE);
        tick();
        check("n2 released", {n2_rgb_vld, n2_busy}, 2'b00);

        for (int i = 0; i < 9; i++) run_pixel($sformatf("tbl%0d", i), tbl[i], 0);

        check("ovr before", ovr, 1'b0);
        run_pixel("overrun", mk(32'h8000, 32'h8000, 0, 0, 2, 6, 6, 6, 0, CORE), 3);
        check("ovr set", ovr, 1'b1);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       rv.v[i] = $urandom;
                    1:       rv.v[i] = $urandom_range(0, 32'h6000);
                    2:       rv.v[i] = $urandom_range(0, 32'h1_0000);
                    default: rv.v[i] = '0;
                endcase
                rv.d[i] = 8'($urandom_range(2, 12));
            end
            rv.hold = $urandom_range(0, 3);
            rv.exp  = model(rv.v);
            run_pixel($sformatf("rnd%0d", n), rv, 0);
        end

        run_pixel("pre-tmo", mk(32'h1_0000, 0, 0, 0, 2, 2, 2, 2, 0, CORE), 0);

        // Ball 3 never edges: forced background pixel after TIMEOUT+1 WAIT cycles.
        px_stb = 1'b1;
        tick();
        px_stb = 1'b0; ball_vld = '0; s = cyc; seen = -1;
        for (int k = 1; k <= 1100 && seen < 0; k++) begin
            if (k == 2) ball_vld[2:0] = 3'b111;
            tick();
            if (cyc == s + TMO) check("tmo early", tmo, 1'b0);
            if (rgb_vld) seen = cyc;
        end
        check("tmo cycle", seen - s, TMO + 1);
        check("tmo flag", tmo, 1'b1);
        check("tmo rgb", rgb, BG);
        rgb_rdy = 1'b1;
        tick();
        rgb_rdy = 1'b0;
        check("tmo released", busy, 1'b0);

        // Ball 0 stays high across px_stb; only its later fresh edge is taken.
        ball_vld = 4'b0001; ball_out[31:0] = 32'h0001_0000;
        tick(); tick();
        px_stb = 1'b1;
        tick();
        px_stb = 1'b0; ball_vld[3:1] = '0;
        tick();
        ball_vld[3:1] = 3'b111; ball_out[127:32] = '0;
        tick();
        repeat (10) tick();
        check("stale ignored", {rgb_vld, busy}, 2'b01);
        ball_vld[0] = 1'b0;
        tick();
        ball_vld[0] = 1'b1; ball_out[31:0] = 32'h8000; s = cyc; seen = -1;
        for (int k = 1; k <= 30 && seen < 0; k++) begin
            tick();
            if (rgb_vld) seen = cyc;
        end
        check("stale latency", seen - s, 32'd7);
        check("stale rgb", rgb, EDGE);
        rgb_rdy = 1'b1;
        tick();
        rgb_rdy = 1'b0;

        // Reset while summing drops the pixel entirely.
        px_stb = 1'b1;
        tick();
        px_stb = 1'b0; ball_vld = '0;
        tick();
        ball_vld = '1; ball_out = {4{32'h0001_0000}};
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst rgb", rgb, BG);
        check("mid rst flags", {rgb_vld, busy, ovr, tmo}, 4'b0000);
        bad = 0;
        repeat (20) begin
            tick();
            if (rgb_vld || busy) bad = 1;
        end
        check("no pixel after rst", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
